// File: rtl/if_id_stage.sv
// IF stage PC plus IF/ID pipeline register with stall/flush control.
// Define IF_ID_STALL_COUNT_EN to add the Stall_Count port and counter.
module if_id_stage #(
  parameter logic [63:0] RESET_PC  = 64'h0,
  parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        PCWrite,
  input  logic        IF_ID_Write,
  input  logic        Branch_Taken,
  input  logic [63:0] Branch_Target,
  input  logic [31:0] Instr_In,
  output logic [63:0] PC_Out,
  output logic [63:0] IF_ID_PC,
  output logic [31:0] IF_ID_Instr,
`ifdef IF_ID_STALL_COUNT_EN
  output logic        IF_ID_Valid,
  output logic [31:0] Stall_Count
`else
  output logic        IF_ID_Valid
`endif
);

  typedef enum logic [1:0] {
    START,
    RUN,
    STALL,
    FLUSH
  } state_t;

  state_t state;

  logic        stall;
  logic [63:0] pc_next;
  logic [63:0] br_pc;

  assign stall   = !PCWrite || !IF_ID_Write;
  assign pc_next = PC_Out + 64'd4;
  assign br_pc   = {Branch_Target[63:2], 2'b00};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= START;
      PC_Out      <= RESET_PC;
      IF_ID_PC    <= '0;
      IF_ID_Instr <= NOP_INSTR;
      IF_ID_Valid <= 1'b0;
    end else if (state == START) begin
      // IF/ID is already a bubble; only a redirect can move the PC
      if (Branch_Taken) begin
        PC_Out <= br_pc;
        state  <= FLUSH;
      end else begin
        state  <= RUN;
      end
    end else if (Branch_Taken) begin
      PC_Out      <= br_pc;
      IF_ID_PC    <= '0;
      IF_ID_Instr <= NOP_INSTR;
      IF_ID_Valid <= 1'b0;
      state       <= FLUSH;
    end else if (stall) begin
      if (PCWrite) begin
        PC_Out <= pc_next;
      end
      if (IF_ID_Write) begin
        IF_ID_PC    <= PC_Out;
        IF_ID_Instr <= Instr_In;
        IF_ID_Valid <= 1'b1;
      end
      state <= STALL;
    end else begin
      PC_Out      <= pc_next;
      IF_ID_PC    <= PC_Out;
      IF_ID_Instr <= Instr_In;
      IF_ID_Valid <= 1'b1;
      state       <= RUN;
    end
  end

`ifdef IF_ID_STALL_COUNT_EN
  logic cnt_inc;

  assign cnt_inc = (state != START) && !Branch_Taken && stall;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      Stall_Count <= '0;
    end else if (cnt_inc && Stall_Count != 32'hFFFF_FFFF) begin
      Stall_Count <= Stall_Count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_if_id_stage.sv
// Self-checking bench for if_id_stage: directed table plus
// randomized run against a per-cycle reference model.
module tb_if_id_stage;

  localparam logic [31:0] NOP = 32'h00000013;

  logic        clk;
  logic        reset;
  logic        PCWrite;
  logic        IF_ID_Write;
  logic        Branch_Taken;
  logic [63:0] Branch_Target;
  logic [31:0] Instr_In;
  logic [63:0] PC_Out;
  logic [63:0] IF_ID_PC;
  logic [31:0] IF_ID_Instr;
  logic        IF_ID_Valid;
`ifdef IF_ID_STALL_COUNT_EN
  logic [31:0] Stall_Count;
`endif

  int checks;
  int errors;

  if_id_stage dut (
    .clk          (clk),
    .reset        (reset),
    .PCWrite      (PCWrite),
    .IF_ID_Write  (IF_ID_Write),
    .Branch_Taken (Branch_Taken),
    .Branch_Target(Branch_Target),
    .Instr_In     (Instr_In),
    .PC_Out       (PC_Out),
    .IF_ID_PC     (IF_ID_PC),
    .IF_ID_Instr  (IF_ID_Instr),
`ifdef IF_ID_STALL_COUNT_EN
    .IF_ID_Valid  (IF_ID_Valid),
    .Stall_Count  (Stall_Count)
`else
    .IF_ID_Valid  (IF_ID_Valid)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] imem(input logic [63:0] a);
    logic [15:0] lo;
    lo = a[15:0] + 16'd1;
    return {16'hAAAA, lo};
  endfunction

  assign Instr_In = imem(PC_Out);

  // reference model state
  logic [63:0] m_pc;
  logic [63:0] m_ifpc;
  logic [31:0] m_instr;
  logic        m_valid;
  logic [31:0] m_cnt;
  bit          m_first;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".pc"}, PC_Out, m_pc);
    chk({tag, ".ifpc"}, IF_ID_PC, m_ifpc);
    chk({tag, ".instr"}, {32'd0, IF_ID_Instr}, {32'd0, m_instr});
    chk({tag, ".valid"}, {63'd0, IF_ID_Valid}, {63'd0, m_valid});
`ifdef IF_ID_STALL_COUNT_EN
    chk({tag, ".cnt"}, {32'd0, Stall_Count}, {32'd0, m_cnt});
`endif
  endtask

  task automatic model_reset();
    m_pc    = 64'h0;
    m_ifpc  = 64'h0;
    m_instr = NOP;
    m_valid = 1'b0;
    m_cnt   = 32'd0;
    m_first = 1'b1;
  endtask

  // one clock of the fetch rules, applied to the pre-edge state
  task automatic model_step(input bit pw, input bit iw, input bit bt,
                            input logic [63:0] tg);
    logic [63:0] al;
    al = tg & ~64'd3;
    if (m_first) begin
      m_first = 1'b0;
      if (bt) m_pc = al;
    end else if (bt) begin
      m_pc    = al;
      m_ifpc  = 64'h0;
      m_instr = NOP;
      m_valid = 1'b0;
    end else if (!pw || !iw) begin
      if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
      if (iw) begin
        m_ifpc  = m_pc;
        m_instr = imem(m_pc);
        m_valid = 1'b1;
      end
      if (pw) m_pc = m_pc + 64'd4;
    end else begin
      m_ifpc  = m_pc;
      m_instr = imem(m_pc);
      m_valid = 1'b1;
      m_pc    = m_pc + 64'd4;
    end
  endtask

  task automatic drive(input bit pw, input bit iw, input bit bt,
                       input logic [63:0] tg);
    PCWrite       = pw;
    IF_ID_Write   = iw;
    Branch_Taken  = bt;
    Branch_Target = tg;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  typedef struct {
    bit          pw;
    bit          iw;
    bit          bt;
    logic [63:0] tg;
    logic [63:0] pc;
    logic [63:0] ifpc;
    logic [31:0] instr;
    bit          valid;
    logic [31:0] cnt;
  } vec_t;

  vec_t vt[14];

  initial begin
    checks = 0;
    errors = 0;
    drive(1'b1, 1'b1, 1'b0, 64'h0);

    vt[0]  = '{1,1,0,64'h0,   64'h0, 64'h0, NOP, 0, 0};
    vt[1]  = '{1,1,0,64'h0,   64'h4, 64'h0, 32'hAAAA0001, 1, 0};
    vt[2]  = '{1,1,0,64'h0,   64'h8, 64'h4, 32'hAAAA0005, 1, 0};
    vt[3]  = '{0,0,0,64'h0,   64'h8, 64'h4, 32'hAAAA0005, 1, 1};
    vt[4]  = '{0,0,0,64'h0,   64'h8, 64'h4, 32'hAAAA0005, 1, 2};
    vt[5]  = '{1,1,0,64'h0,   64'hC, 64'h8, 32'hAAAA0009, 1, 2};
    vt[6]  = '{0,1,0,64'h0,   64'hC, 64'hC, 32'hAAAA000D, 1, 3};
    vt[7]  = '{1,0,0,64'h0,   64'h10, 64'hC, 32'hAAAA000D, 1, 4};
    vt[8]  = '{0,1,1,64'h103, 64'h100, 64'h0, NOP, 0, 4};
    vt[9]  = '{1,1,0,64'h0,   64'h104, 64'h100, 32'hAAAA0101, 1, 4};
    vt[10] = '{1,1,1,64'hFFFF_FFFF_FFFF_FFFE,
               64'hFFFF_FFFF_FFFF_FFFC, 64'h0, NOP, 0, 4};
    vt[11] = '{1,1,0,64'h0,   64'h0, 64'hFFFF_FFFF_FFFF_FFFC,
               32'hAAAAFFFD, 1, 4};
    vt[12] = '{1,0,1,64'h40,  64'h40, 64'h0, NOP, 0, 4};
    vt[13] = '{0,0,0,64'h0,   64'h40, 64'h0, NOP, 0, 5};

    // asynchronous reset, checked before any clock edge
    reset = 1'b1;
    #2;
    model_reset();
    chk_all("rst0");
    @(posedge clk);
    #1;
    reset = 1'b0;

    for (int i = 0; i < 14; i++) begin
      drive(vt[i].pw, vt[i].iw, vt[i].bt, vt[i].tg);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d.pc", i), PC_Out, vt[i].pc);
      chk($sformatf("v%0d.ifpc", i), IF_ID_PC, vt[i].ifpc);
      chk($sformatf("v%0d.instr", i), {32'd0, IF_ID_Instr},
          {32'd0, vt[i].instr});
      chk($sformatf("v%0d.valid", i), {63'd0, IF_ID_Valid},
          {63'd0, vt[i].valid});
`ifdef IF_ID_STALL_COUNT_EN
      chk($sformatf("v%0d.cnt", i), {32'd0, Stall_Count},
          {32'd0, vt[i].cnt});
`endif
    end

    // reset mid-stall with a branch pending on the inputs
    drive(1'b0, 1'b0, 1'b1, 64'h200);
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    chk_all("amid");
    #3;
    reset = 1'b0;
    drive(1'b1, 1'b1, 1'b0, 64'h0);
    @(posedge clk);
    #1;
    model_step(1'b1, 1'b1, 1'b0, 64'h0);
    chk_all("start");
    @(posedge clk);
    #1;
    model_step(1'b1, 1'b1, 1'b0, 64'h0);
    chk_all("first");

    // randomized run against the reference model
    do_reset();
    for (int c = 0; c < 400; c++) begin
      bit          pw;
      bit          iw;
      bit          bt;
      logic [63:0] tg;
      pw = ($urandom_range(3) != 0);
      iw = ($urandom_range(3) != 0);
      bt = ($urandom_range(7) == 0);
      tg = {$urandom, $urandom};
      if ($urandom_range(3) == 0) tg = 64'hFFFF_FFFF_FFFF_FFF0 | tg[3:0];
      drive(pw, iw, bt, tg);
      model_step(pw, iw, bt, tg);
      @(posedge clk);
      #1;
      chk_all($sformatf("r%0d", c));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
